// File: rtl/mtm_alu_pkg.sv
// Shared types and helpers for the mtm_Alu serial front-end: opcodes, packet
// fields, error flags and the CRC4 used to protect each command frame.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CMD  = 1'b1
  } pkt_type_t;

  typedef struct packed {
    pkt_type_t  ptype;
    logic [7:0] payload;
  } packet_t;

  // Ordered so the packed value reads {ERR_DATA, ERR_CRC, ERR_OP}.
  typedef struct packed {
    logic data;
    logic crc;
    logic op;
  } err_flags_t;

  localparam err_flags_t ERR_NONE = err_flags_t'(3'b000);
  localparam err_flags_t ERR_DATA = err_flags_t'(3'b100);
  localparam err_flags_t ERR_CRC  = err_flags_t'(3'b010);
  localparam err_flags_t ERR_OP   = err_flags_t'(3'b001);

  typedef enum logic [2:0] {
    RX_WAIT_HIGH,
    RX_IDLE,
    RX_TYPE,
    RX_PAYLOAD,
    RX_STOP
  } rx_state_t;

  // Poly x^4+x+1, init 0, message bits consumed MSB first.
  function automatic logic [3:0] calc_crc4(input logic [67:0] data);
    logic [3:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ data[i];
      crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return crc;
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: op_is_legal = 1'b1;
      default:                       op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mtm_alu_packet_rx.sv
// Bit-level receiver: frames 11-bit packets (start, type, 8 payload bits, stop)
// from sin and reports each one with a single-cycle pulse.
module mtm_alu_packet_rx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       pkt_valid,
  output pkt_type_t  pkt_type,
  output logic [7:0] pkt_payload,
  output logic       frame_err
);

  rx_state_t  state, state_nxt;
  logic [2:0] bit_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RX_WAIT_HIGH;
      bit_cnt     <= '0;
      pkt_type    <= PKT_DATA;
      pkt_payload <= '0;
    end else begin
      state <= state_nxt;
      if (state == RX_TYPE) begin
        pkt_type <= pkt_type_t'(sin);
        bit_cnt  <= 3'd7;
      end
      if (state == RX_PAYLOAD) begin
        pkt_payload <= {pkt_payload[6:0], sin};
        bit_cnt     <= bit_cnt - 3'd1;
      end
    end
  end

  // NOTE: next-state defaults to the current state before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_WAIT_HIGH: if (sin)  state_nxt = RX_IDLE;
      RX_IDLE:      if (!sin) state_nxt = RX_TYPE;
      RX_TYPE:                state_nxt = RX_PAYLOAD;
      RX_PAYLOAD:   if (bit_cnt == 3'd0) state_nxt = RX_STOP;
      // A low stop bit means we lost alignment; resync on the next idle high.
      RX_STOP:      state_nxt = sin ? RX_IDLE : RX_WAIT_HIGH;
      default:      state_nxt = RX_WAIT_HIGH;
    endcase
  end

  assign pkt_valid = (state == RX_STOP) &&  sin;
  assign frame_err = (state == RX_STOP) && !sin;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial input front-end of mtm_Alu: assembles B/A operands and opcode from a
// packet stream, validates the frame and offers one command per frame.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int N_DATA = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        overrun
);

  localparam int CNT_W = $clog2(N_DATA + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_DATA);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(N_DATA + 1);

  logic       pkt_valid, frame_err;
  pkt_type_t  pkt_type;
  logic [7:0] pkt_payload;

  mtm_alu_packet_rx u_rx (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .pkt_valid   (pkt_valid),
    .pkt_type    (pkt_type),
    .pkt_payload (pkt_payload),
    .frame_err   (frame_err)
  );

  logic [63:0]      operands;   // {B, A} once N_DATA bytes have arrived
  logic [CNT_W-1:0] data_cnt;

  logic       data_done, cmd_done, load, drop;
  logic [2:0] cmd_op;
  logic [3:0] cmd_crc;
  err_flags_t err;

  assign data_done = pkt_valid && (pkt_type == PKT_DATA);
  assign cmd_done  = pkt_valid && (pkt_type == PKT_CMD);
  assign cmd_op    = pkt_payload[6:4];
  assign cmd_crc   = pkt_payload[3:0];

  // Checks are prioritised: a short/long frame masks CRC, a bad CRC masks op.
  always_comb begin
    err = ERR_NONE;
    if (data_cnt != CNT_FULL)
      err = ERR_DATA;
    else if (calc_crc4({operands, 1'b1, cmd_op}) != cmd_crc)
      err = ERR_CRC;
    else if (!op_is_legal(cmd_op))
      err = ERR_OP;
  end

  // A new result may land in the same cycle the held one is accepted.
  assign load = cmd_done && (!out_valid || out_ready);
  assign drop = cmd_done &&   out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      operands  <= '0;
      data_cnt  <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_err   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (cmd_done || frame_err)
        data_cnt <= '0;
      else if (data_done && data_cnt != CNT_SAT)
        data_cnt <= data_cnt + 1'b1;

      if (data_done)
        operands <= {operands[55:0], pkt_payload};

      overrun <= drop;

      if (load) begin
        out_valid <= 1'b1;
        out_b     <= operands[63:32];
        out_a     <= operands[31:0];
        out_op    <= cmd_op;
        out_err   <= err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer: drives packet streams on sin and
// compares the offered commands against hand-derived values.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err;
  logic        overrun;

  int vectors     = 0;
  int miscompares = 0;

  mtm_alu_deserializer #(.N_DATA(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_err   (out_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Remainder of msg*x^4 divided by x^4+x+1 (long division form).
  function automatic logic [3:0] ref_crc4(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  // Called at a negedge; the bit is sampled on the following posedge.
  task automatic drive_bit(input logic b);
    sin = b;
    @(negedge clk);
  endtask

  task automatic send_packet(input logic ptype, input logic [7:0] payload,
                             input logic stop_bit);
    drive_bit(1'b0);
    drive_bit(ptype);
    for (int i = 7; i >= 0; i--) drive_bit(payload[i]);
    drive_bit(stop_bit);
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a,
                            input logic [2:0] op, input logic [3:0] crc_xor,
                            input int ndata);
    logic [63:0] ba;
    logic [3:0]  crc;
    ba  = {b, a};
    crc = ref_crc4({b, a, 1'b1, op}) ^ crc_xor;
    for (int i = 0; i < ndata; i++) send_packet(1'b0, ba[63 - 8*(i % 8) -: 8], 1'b1);
    send_packet(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic expect_cmd(input string name, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] op);
    vectors++;
    if (out_valid !== 1'b1 || out_err !== 3'b000 || out_a !== a || out_b !== b || out_op !== op) begin
      miscompares++;
      $display("FAIL %s: got v=%b err=%b a=%h b=%h op=%b, want v=1 err=000 a=%h b=%h op=%b",
               name, out_valid, out_err, out_a, out_b, out_op, a, b, op);
    end
  endtask

  task automatic expect_err(input string name, input logic [2:0] err);
    vectors++;
    if (out_valid !== 1'b1 || out_err !== err) begin
      miscompares++;
      $display("FAIL %s: got v=%b err=%b, want v=1 err=%b", name, out_valid, out_err, err);
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  task automatic expect_zero_outputs(input string name);
    vectors++;
    if (out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0 ||
        out_op !== 3'd0 || out_err !== 3'd0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got v=%b a=%h b=%h op=%b err=%b ovr=%b, want all zero",
               name, out_valid, out_a, out_b, out_op, out_err, overrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sin = 1'b1; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    expect_zero_outputs("reset_state");
    rst = 1'b0;
    drive_bit(1'b1); drive_bit(1'b1);
  endtask

  task automatic test_add();
    logic [63:0] ba;
    logic [7:0]  cmd;
    ba  = {32'd20, 32'd10};
    cmd = {1'b0, 3'b100, ref_crc4({32'd20, 32'd10, 1'b1, 3'b100})};
    for (int i = 0; i < 8; i++) send_packet(1'b0, ba[63 - 8*i -: 8], 1'b1);
    drive_bit(1'b0); drive_bit(1'b1);
    for (int i = 7; i >= 0; i--) drive_bit(cmd[i]);
    expect_bit("add_valid_before_stop", out_valid, 1'b0);
    drive_bit(1'b1);
    expect_cmd("add_result", 32'd10, 32'd20, 3'b100);
    drive_bit(1'b1);
    expect_bit("add_valid_drops", out_valid, 1'b0);
  endtask

  task automatic test_data_count();
    send_frame(32'd2, 32'd1, 3'b000, 4'h0, 7);
    expect_err("seven_data", 3'b100);
    drive_bit(1'b1);
    send_frame(32'd2, 32'd1, 3'b000, 4'h0, 9);
    expect_err("nine_data", 3'b100);
    drive_bit(1'b1);
  endtask

  task automatic test_crc_and_op();
    send_frame(32'd20, 32'd10, 3'b001, 4'h1, 8);
    expect_err("bad_crc", 3'b010);
    drive_bit(1'b1);
    send_frame(32'd20, 32'd10, 3'b010, 4'h0, 8);
    expect_err("bad_op", 3'b001);
    drive_bit(1'b1);
    send_frame(32'h0000_00ff, 32'hffff_ff00, 3'b001, 4'h0, 8);
    expect_cmd("or_result", 32'hffff_ff00, 32'h0000_00ff, 3'b001);
    drive_bit(1'b1);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_frame(32'd30, 32'd100, 3'b101, 4'h0, 8);
    expect_cmd("b2b_first", 32'd100, 32'd30, 3'b101);
    expect_bit("b2b_no_overrun_yet", overrun, 1'b0);
    send_frame(32'd9, 32'd7, 3'b101, 4'h0, 8);
    expect_bit("b2b_overrun_pulse", overrun, 1'b1);
    expect_cmd("b2b_first_held", 32'd100, 32'd30, 3'b101);
    drive_bit(1'b1);
    expect_bit("b2b_overrun_one_cycle", overrun, 1'b0);
    expect_cmd("b2b_still_held", 32'd100, 32'd30, 3'b101);
    out_ready = 1'b1;
    drive_bit(1'b1);
    expect_bit("b2b_accepted", out_valid, 1'b0);
  endtask

  task automatic test_frame_error();
    out_ready = 1'b1;
    send_packet(1'b0, 8'h11, 1'b1);
    send_packet(1'b0, 8'h22, 1'b1);
    send_packet(1'b0, 8'h33, 1'b0);
    expect_bit("ferr_no_output", out_valid, 1'b0);
    drive_bit(1'b1); drive_bit(1'b1);
    send_frame(32'hcafe_f00d, 32'h1234_5678, 3'b100, 4'h0, 8);
    expect_cmd("ferr_recovered", 32'h1234_5678, 32'hcafe_f00d, 3'b100);
    drive_bit(1'b1);
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b0;
    send_frame(32'd6, 32'd5, 3'b100, 4'h0, 8);
    expect_cmd("rst_pre_frame", 32'd5, 32'd6, 3'b100);
    for (int i = 0; i < 4; i++) send_packet(1'b0, 8'h5a, 1'b1);
    drive_bit(1'b0); drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rst = 1'b1; sin = 1'b0;
    @(negedge clk);
    expect_zero_outputs("rst_mid_payload");
    rst = 1'b0;
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b0);
    drive_bit(1'b1);
    out_ready = 1'b1;
    send_frame(32'd3, 32'ha5a5_0001, 3'b001, 4'h0, 8);
    expect_cmd("rst_post_frame", 32'ha5a5_0001, 32'd3, 3'b001);
    drive_bit(1'b1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_data_count();
    test_crc_and_op();
    test_back_to_back();
    test_frame_error();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
